// File: rtl/cam_seq_pkg.sv
// Shared sequencer definitions: state encoding, default cycle budgets and
// the state-to-output decode used by the camera power sequencer.
package cam_seq_pkg;

  typedef enum logic [2:0] {
    ST_PWDN      = 3'd0,
    ST_RST       = 3'd1,
    ST_BOOT      = 3'd2,
    ST_INIT_REQ  = 3'd3,
    ST_INIT_WAIT = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } seq_state_e;

  localparam int unsigned T_PWDN_DEF       = 500_000;
  localparam int unsigned T_RST_DEF        = 100_000;
  localparam int unsigned T_BOOT_DEF       = 1_000_000;
  localparam int unsigned INIT_TIMEOUT_DEF = 5_000_000;
  localparam int unsigned MAX_RETRY_DEF    = 3;

  typedef struct packed {
    logic cam_pwdn;
    logic cam_rst_n;
    logic init_req;
    logic pipe_rst_n;
    logic seq_done;
    logic seq_fail;
  } seq_out_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Output pattern for a state; registered from the next state by the FSM.
  function automatic seq_out_t decode_out(input seq_state_e s);
    seq_out_t o;
    o = '{cam_pwdn: 1'b1, cam_rst_n: 1'b0, init_req: 1'b0,
          pipe_rst_n: 1'b0, seq_done: 1'b0, seq_fail: 1'b0};
    case (s)
      ST_RST:       o.cam_pwdn = 1'b0;
      ST_BOOT,
      ST_INIT_WAIT: begin o.cam_pwdn = 1'b0; o.cam_rst_n = 1'b1; end
      ST_INIT_REQ:  begin o.cam_pwdn = 1'b0; o.cam_rst_n = 1'b1; o.init_req = 1'b1; end
      ST_RUN:       begin o.cam_pwdn = 1'b0; o.cam_rst_n = 1'b1;
                          o.pipe_rst_n = 1'b1; o.seq_done = 1'b1; end
      ST_FAIL:      o.seq_fail = 1'b1;
      default:      ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dly_timer.sv
// Clearable up-counter with a terminal-count compare against a per-state limit.
module dly_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clr_i) cnt_q <= '0;
    else                   cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/cam_pwr_seq.sv
// Camera power-up sequencer: PWDN -> RST -> BOOT -> init request, then holds
// the pipeline in reset until init completes, power-cycling on init timeout.
module cam_pwr_seq
  import cam_seq_pkg::*;
#(
  parameter int unsigned T_PWDN       = T_PWDN_DEF,
  parameter int unsigned T_RST        = T_RST_DEF,
  parameter int unsigned T_BOOT       = T_BOOT_DEF,
  parameter int unsigned INIT_TIMEOUT = INIT_TIMEOUT_DEF,
  parameter int unsigned MAX_RETRY    = MAX_RETRY_DEF,
  localparam int unsigned RW = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  // init_req is a one-cycle start pulse; init_done (level or pulse) is only
  // sampled in INIT_WAIT, so anything arriving earlier is dropped.
  input  logic          init_done,
  output logic          cam_pwdn,
  output logic          cam_rst_n,
  output logic          init_req,
  output logic          pipe_rst_n,
  output logic          seq_done,
  output logic          seq_fail,
  output logic [2:0]    dbg_state,
  output logic [RW-1:0] dbg_retry
);

  localparam int unsigned T_MAX = max2(max2(T_PWDN, T_RST), max2(T_BOOT, INIT_TIMEOUT));
  localparam int unsigned CW    = ($clog2(T_MAX) > 0) ? $clog2(T_MAX) : 1;

  seq_state_e    state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  seq_out_t      out_q;
  logic [CW-1:0] tc_val;
  logic          tc, clr;

  always_comb begin
    tc_val = '0;
    case (state_q)
      ST_PWDN:      tc_val = CW'(T_PWDN - 1);
      ST_RST:       tc_val = CW'(T_RST - 1);
      ST_BOOT:      tc_val = CW'(T_BOOT - 1);
      ST_INIT_WAIT: tc_val = CW'(INIT_TIMEOUT - 1);
      default:      tc_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      ST_PWDN:     if (tc) state_d = ST_RST;
      ST_RST:      if (tc) state_d = ST_BOOT;
      ST_BOOT:     if (tc) state_d = ST_INIT_REQ;
      ST_INIT_REQ: state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        // done beats a timeout landing on the same edge
        if (init_done) begin
          state_d = ST_RUN;
        end else if (tc) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_PWDN;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign clr = (state_d != state_q);

  dly_timer #(.W(CW)) u_dly_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (clr),
    .tc_val_i (tc_val),
    .tc_o     (tc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_PWDN;
      retry_q <= '0;
      out_q   <= decode_out(ST_PWDN);
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      out_q   <= decode_out(state_d);
    end
  end

  assign cam_pwdn   = out_q.cam_pwdn;
  assign cam_rst_n  = out_q.cam_rst_n;
  assign init_req   = out_q.init_req;
  assign pipe_rst_n = out_q.pipe_rst_n;
  assign seq_done   = out_q.seq_done;
  assign seq_fail   = out_q.seq_fail;
  assign dbg_state  = state_q;
  assign dbg_retry  = retry_q;

endmodule
